// File: rtl/magic_nor_sequencer.sv
// magic_nor_sequencer
// Executes a stored NOR/NOT/INIT micro-program over a row of MAGIC memristor
// cells, one instruction per clock. The program is loaded through a simple
// write port while idle; a start request loads the row from in_vec and runs
// the program from address 0 until an END word or the end of program memory.
//
// Optional feature: define MAGIC_INIT_CHECK_EN to model MAGIC init physics.
// A per-cell init mask is kept; a NOT/NOR into a cell that was not INITed
// since its last logic write can only pull the cell 1->0, and it raises the
// sticky err flag. Without the macro, results are written unconditionally
// and err is tied low.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   prog_we    program write strobe (honoured only while idle)
//   prog_addr  program write address
//   prog_data  instruction word {op[1:0], dst, src_a, src_b}
//   start      start request (ignored while busy)
//   in_vec     initial cell values, sampled on an accepted start
//   busy       program executing
//   done       one-cycle completion pulse
//   err        sticky init violation flag
//   out_vec    current cell states (meaningful while busy=0)
//
// Handshake: start is accepted on any rising edge where busy=0; busy rises on
// that same edge. done pulses for exactly one cycle as busy falls, and a start
// presented during that done cycle is accepted.
module magic_nor_sequencer #(
  parameter int NCELL  = 16,
  parameter int NINSTR = 16,
  localparam int AW = $clog2(NCELL),
  localparam int PW = $clog2(NINSTR),
  localparam int IW = 2 + 3*AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prog_we,
  input  logic [PW-1:0]    prog_addr,
  input  logic [IW-1:0]    prog_data,
  input  logic             start,
  input  logic [NCELL-1:0] in_vec,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [NCELL-1:0] out_vec
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [1:0] OP_END  = 2'b00;
  localparam logic [1:0] OP_NOT  = 2'b01;
  localparam logic [1:0] OP_NOR  = 2'b10;
  localparam logic [1:0] OP_INIT = 2'b11;

  state_t           state;
  logic [IW-1:0]    prog [NINSTR];
  // One extra pc bit: after the last word has executed, pc points one past
  // the program and that slot behaves as an implicit END, so a full program
  // takes the same "ops + 1" edges as one ending in an explicit END.
  logic [PW:0]      pc;
  logic [NCELL-1:0] cells;
  logic [NCELL-1:0] next_cells;

  logic [IW-1:0]    instr;
  logic [1:0]       op;
  logic [AW-1:0]    dst;
  logic [AW-1:0]    src_a;
  logic [AW-1:0]    src_b;
  logic             result;

  assign instr  = (pc < (PW+1)'(NINSTR)) ? prog[pc[PW-1:0]] : '0;
  assign op     = instr[IW-1:IW-2];
  assign dst    = instr[3*AW-1:2*AW];
  assign src_a  = instr[2*AW-1:AW];
  assign src_b  = instr[AW-1:0];
  // Sources are read from the current register value, so dst == src is fine.
  assign result = (op == OP_NOT) ? ~cells[src_a] : ~(cells[src_a] | cells[src_b]);

  assign out_vec = cells;

`ifdef MAGIC_INIT_CHECK_EN
  logic [NCELL-1:0] init_mask;
  logic [NCELL-1:0] next_mask;
  logic             viol;
  logic             err_q;

  assign err = err_q;

  always_comb begin
    next_cells = cells;
    next_mask  = init_mask;
    viol       = 1'b0;
    case (op)
      OP_INIT: begin
        next_cells[dst] = 1'b1;
        next_mask[dst]  = 1'b1;
      end
      OP_NOT, OP_NOR: begin
        if (init_mask[dst]) begin
          next_cells[dst] = result;
        end else begin
          // Un-initialised cell: MAGIC can only switch it 1->0.
          next_cells[dst] = cells[dst] & result;
          viol            = 1'b1;
        end
        next_mask[dst] = 1'b0;
      end
      default: ;
    endcase
  end
`else
  assign err = 1'b0;

  always_comb begin
    next_cells = cells;
    case (op)
      OP_INIT:        next_cells[dst] = 1'b1;
      OP_NOT, OP_NOR: next_cells[dst] = result;
      default: ;
    endcase
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= '0;
      cells <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      for (int i = 0; i < NINSTR; i++) prog[i] <= '0;
`ifdef MAGIC_INIT_CHECK_EN
      init_mask <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      // Writes land even on the start edge; the word is fetched later.
      if (state == S_IDLE && prog_we) prog[prog_addr] <= prog_data;
      case (state)
        S_IDLE: begin
          if (start) begin
            cells <= in_vec;
            pc    <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
`ifdef MAGIC_INIT_CHECK_EN
            init_mask <= '0;
            err_q     <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          if (op == OP_END) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            cells <= next_cells;
            pc    <= pc + 1'b1;
`ifdef MAGIC_INIT_CHECK_EN
            init_mask <= next_mask;
            err_q     <= err_q | viol;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
